w1_load_ctrl: RTL and testbench
===============================

W1_LOAD_CTRL -- requirements
Module: w1_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, weight-memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, weight word width.
REQ-003 SHALL have parameter NUM_WORDS, default 784, words per load; legal range 1..2^ADDR_W.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port start  input  1  pulse that begins a load sequence.
REQ-007 SHALL have port s_valid  input  1  upstream weight word valid.
REQ-008 SHALL have port s_data  input  DATA_W  upstream weight word.
REQ-009 SHALL have port s_ready  output  1  this block accepts s_data.
REQ-010 SHALL have port comp_addr  input  ADDR_W  compute-phase read address.
REQ-011 SHALL have port mem_addr  output  ADDR_W  weight-memory address (muxed).
REQ-012 SHALL have port mem_wdata  output  DATA_W  weight-memory write data.
REQ-013 SHALL have port mem_we  output  1  weight-memory write enable.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port load_done  output  1  one-cycle pulse when the last word is written.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, DONE; reset state IDLE.
REQ-017 IDLE->LOAD on start=1; counter cleared to 0 in the same edge.
REQ-018 In LOAD, s_ready SHALL be 1; in IDLE and DONE, s_ready SHALL be 0.
REQ-019 A transfer occurs on a cycle with s_valid && s_ready; mem_we, mem_wdata, mem_addr are registered and SHALL present that word with address = current count one cycle later (latency 1).
REQ-020 Counter SHALL increment by 1 per transfer only; s_valid low stalls without writing.
REQ-021 Transfer with count == NUM_WORDS-1 SHALL move FSM to DONE; no wrap-around, no further words accepted.
REQ-022 DONE SHALL last exactly one cycle, assert load_done for that cycle, and then return to IDLE.
REQ-023 busy SHALL be 1 in LOAD and DONE, 0 in IDLE.
REQ-024 When not writing (mem_we=0) and in IDLE, mem_addr SHALL follow comp_addr combinationally; in LOAD/DONE, mem_addr SHALL be the registered load address.
REQ-025 start while busy SHALL be ignored; start and s_valid in the same IDLE cycle SHALL NOT transfer that cycle.
REQ-026 NUM_WORDS=1: a single transfer SHALL go LOAD->DONE.

Reset
REQ-027 rst_n=0 at an edge SHALL force IDLE, counter 0, mem_we 0, mem_wdata 0, load_done 0, busy 0, s_ready 0, including during LOAD; the partial load is abandoned.
REQ-028 After reset, mem_addr SHALL equal comp_addr.

Configuration
REQ-029 Macro W1_LOAD_CHECKSUM_EN defined: output checksum [DATA_W+ADDR_W-1:0] SHALL be the running sum of accepted words, cleared on start and reset, stable after load_done.
REQ-030 Macro undefined: checksum port and adder SHALL be absent; all other behaviour identical.

Structure
REQ-031 The FSM state typedef (IDLE/LOAD/DONE) and default ADDR_W/DATA_W/NUM_WORDS constants SHALL reside in shared package nn_pkg.
REQ-032 The address mux SHALL be sub-module nn_addr_mux (sel, a, b -> y); all other logic stays flat.

Verification
REQ-033 Reset then comp_addr=7, no start -> mem_addr=7, mem_we=0, busy=0.
REQ-034 NUM_WORDS=8, start, s_valid held 1 with data 0x100..0x107 -> writes at addresses 0..7 on consecutive cycles, load_done pulses once, busy drops the next cycle.
REQ-035 NUM_WORDS=8, s_valid toggled 1/0 -> exactly 8 writes, addresses contiguous, no writes on stall cycles.
REQ-036 rst_n low after 3 transfers -> FSM IDLE next edge; a new start restarts at address 0.
REQ-037 start reasserted mid-load -> counter unaffected, 8 total writes.
REQ-038 With W1_LOAD_CHECKSUM_EN, data 1..8 -> checksum=36 after load_done.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and FSM state encoding for the weight-load datapath.
// Defaults for ADDR_W/DATA_W/NUM_WORDS match a 28x28 input layer.
package nn_pkg;

   localparam int NN_ADDR_W    = 10;
   localparam int NN_DATA_W    = 16;
   localparam int NN_NUM_WORDS = 784;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t LOAD = 2'd1;
   localparam state_t DONE = 2'd2;

endpackage

// File: rtl/nn_addr_mux.sv
// Two-way address mux: y = b when sel is high, else a.
module nn_addr_mux #(
   parameter int W = 10
) (
   input  logic         sel,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/w1_load_ctrl.sv
// Streams NUM_WORDS weight words into the weight memory, then hands the port back to compute.
// Optional running checksum of accepted words when W1_LOAD_CHECKSUM_EN is defined.
module w1_load_ctrl
   import nn_pkg::*;
#(
   parameter int ADDR_W    = NN_ADDR_W,
   parameter int DATA_W    = NN_DATA_W,
   parameter int NUM_WORDS = NN_NUM_WORDS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     s_valid,
   input  logic [DATA_W-1:0]        s_data,
   output logic                     s_ready,
   input  logic [ADDR_W-1:0]        comp_addr,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic                     mem_we,
   output logic                     busy,
   output logic                     load_done,
`ifdef W1_LOAD_CHECKSUM_EN
   output logic [DATA_W+ADDR_W-1:0] checksum,
`endif
   output state_t                   state_dbg
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

   state_t              state;
   logic [ADDR_W-1:0]   count;
   logic [ADDR_W-1:0]   load_addr;
   logic [DATA_W-1:0]   wdata_r;
   logic                we_r;
   logic                xfer;

   // Handshake: a word moves on any cycle where s_valid and s_ready are both high;
   // s_ready depends only on state, never on s_valid.
   assign s_ready   = (state == LOAD);
   assign xfer      = s_valid && s_ready;
   assign busy      = (state != IDLE);
   assign load_done = (state == DONE);
   assign mem_we    = we_r;
   assign mem_wdata = wdata_r;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         we_r      <= 1'b0;
         wdata_r   <= '0;
         load_addr <= '0;
      end else begin
         we_r <= xfer;
         if (xfer) begin
            wdata_r   <= s_data;
            load_addr <= count;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  count <= '0;
               end
            end
            LOAD: begin
               // The last word ends the load without advancing the counter, so it never wraps.
               if (xfer) begin
                  if (count == LAST) state <= DONE;
                  else               count <= count + ADDR_W'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef W1_LOAD_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!rst_n)                      checksum <= '0;
      else if (state == IDLE && start) checksum <= '0;
      else if (xfer)                   checksum <= checksum + {{ADDR_W{1'b0}}, s_data};
   end
`endif

   // The memory port belongs to compute only when idle and no write is draining.
   nn_addr_mux #(.W(ADDR_W)) u_addr_mux (
      .sel (we_r || (state != IDLE)),
      .a   (comp_addr),
      .b   (load_addr),
      .y   (mem_addr)
   );

endmodule

// File: tb/tb_w1_load_ctrl.sv
// Self-checking bench for w1_load_ctrl with NUM_WORDS=8; define W1_LOAD_CHECKSUM_EN to cover the checksum.
module tb_w1_load_ctrl;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 16;
   localparam int NW     = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              s_valid = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_ready;
   logic [ADDR_W-1:0] comp_addr = '0;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              busy;
   logic              load_done;
   logic [1:0]        state_dbg;
`ifdef W1_LOAD_CHECKSUM_EN
   logic [DATA_W+ADDR_W-1:0] checksum;
`endif

   w1_load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .comp_addr (comp_addr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .busy      (busy),
      .load_done (load_done),
`ifdef W1_LOAD_CHECKSUM_EN
      .checksum  (checksum),
`endif
      .state_dbg (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: a load is "open" after an accepted start, counts accepted
   // words, and ends with a single completion cycle after word NW-1.
   bit   m_loading = 1'b0;
   bit   m_done    = 1'b0;
   bit   m_we      = 1'b0;
   int   m_count   = 0;
   int   m_sum     = 0;
   bit   mon_en    = 1'b0;
   logic [ADDR_W+DATA_W-1:0] exp_q[$];

   always @(posedge clk) begin
      if (!rst_n) begin
         m_loading = 1'b0;
         m_done    = 1'b0;
         m_we      = 1'b0;
         m_count   = 0;
         m_sum     = 0;
         exp_q.delete();
      end else begin
         m_we = m_loading && s_valid;
         if (m_done) begin
            m_done = 1'b0;
         end else if (m_we) begin
            exp_q.push_back({ADDR_W'(m_count), s_data});
            m_sum   = m_sum + int'(s_data);
            m_count = m_count + 1;
            if (m_count == NW) begin
               m_loading = 1'b0;
               m_done    = 1'b1;
            end
         end else if (!m_loading && start) begin
            m_loading = 1'b1;
            m_count   = 0;
            m_sum     = 0;
         end
      end
   end

   // scoreboard / monitor, sampled on the falling edge
   int cyc = 0;
   int n_writes = 0;
   int n_done = 0;
   int first_cyc = 0;
   int last_cyc = 0;
   int first_addr = -1;

   always @(negedge clk) begin
      if (mon_en) begin
         logic [ADDR_W+DATA_W-1:0] e;
         cyc++;
         n_checks++;
         if (s_ready !== m_loading || busy !== (m_loading || m_done) ||
             load_done !== m_done || mem_we !== m_we) begin
            n_errors++;
            $display("FAIL ctrl_outputs t=%0t ready=%b busy=%b done=%b we=%b required ready=%b busy=%b done=%b we=%b",
                     $time, s_ready, busy, load_done, mem_we, m_loading, m_loading || m_done, m_done, m_we);
         end
         if (mem_we === 1'b1) begin
            n_writes++;
            if (n_writes == 1) begin
               first_cyc  = cyc;
               first_addr = int'(mem_addr);
            end
            last_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL write_unexpected t=%0t addr=%0d data=%h required no write", $time, mem_addr, mem_wdata);
            end else begin
               e = exp_q.pop_front();
               if ({mem_addr, mem_wdata} !== e) begin
                  n_errors++;
                  $display("FAIL write_word t=%0t addr=%0d data=%h required addr=%0d data=%h",
                           $time, mem_addr, mem_wdata, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
               end
            end
         end else if (busy === 1'b0) begin
            n_checks++;
            if (mem_addr !== comp_addr) begin
               n_errors++;
               $display("FAIL idle_addr_mux t=%0t mem_addr=%0d required %0d", $time, mem_addr, comp_addr);
            end
         end
         if (load_done === 1'b1) n_done++;
`ifdef W1_LOAD_CHECKSUM_EN
         if (!m_loading) begin
            n_checks++;
            if (checksum !== (DATA_W+ADDR_W)'(m_sum)) begin
               n_errors++;
               $display("FAIL checksum_track t=%0t checksum=%0d required %0d", $time, checksum, m_sum);
            end
         end
`endif
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clr_counts();
      n_writes   = 0;
      n_done     = 0;
      first_addr = -1;
   endtask

   // valid_mode: 0 always, 1 toggle, 2 random; data_mode: 0 0x100+i, 1 i+1, 2 random
   task automatic run_load(input int valid_mode, input int data_mode, input bit valid_at_start,
                           input int restart_at, input bit start_in_done);
      int i;
      start   = 1'b1;
      s_valid = valid_at_start;
      s_data  = 16'hDEAD;
      tick();
      start = 1'b0;
      i = 0;
      while (!m_done && i < 200) begin
         case (valid_mode)
            0:       s_valid = 1'b1;
            1:       s_valid = (i % 2 == 0);
            default: s_valid = 1'($urandom_range(0, 1));
         endcase
         case (data_mode)
            0:       s_data = DATA_W'(16'h100 + m_count);
            1:       s_data = DATA_W'(m_count + 1);
            default: s_data = DATA_W'($urandom_range(0, 16'hFFFF));
         endcase
         start     = (i == restart_at);
         comp_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
         tick();
         i++;
      end
      if (!m_done) begin
         n_checks++;
         n_errors++;
         $display("FAIL load_timeout cycles=%0d required completion within 200", i);
      end
      s_valid = 1'b0;
      start   = start_in_done;
      tick();
      start = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      mon_en = 1'b1;
      tick();
      rst_n     = 1'b1;
      comp_addr = 10'd7;
      tick();
      n_checks++;
      if (mem_addr !== 10'd7 || mem_we !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || load_done !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_state addr=%0d we=%b busy=%b ready=%b done=%b required 7 0 0 0 0",
                  mem_addr, mem_we, busy, s_ready, load_done);
      end
      comp_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      #1;
      n_checks++;
      if (mem_addr !== comp_addr) begin
         n_errors++;
         $display("FAIL reset_comb_follow mem_addr=%0d required %0d", mem_addr, comp_addr);
      end
   endtask

   task automatic check_load(input string name, input int exp_writes);
      n_checks++;
      if (n_writes !== exp_writes || n_done !== 1 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL %s writes=%0d done_pulses=%0d busy=%b required %0d 1 0",
                  name, n_writes, n_done, busy, exp_writes);
      end
   endtask

   task automatic test_stream();
      clr_counts();
      run_load(0, 0, 1'b0, -1, 1'b0);
      check_load("stream_load", NW);
      n_checks++;
      if (first_addr !== 0 || last_cyc - first_cyc !== NW - 1) begin
         n_errors++;
         $display("FAIL stream_contiguous first_addr=%0d span=%0d required 0 %0d",
                  first_addr, last_cyc - first_cyc, NW - 1);
      end
   endtask

   task automatic test_stall();
      clr_counts();
      run_load(1, 2, 1'b0, -1, 1'b0);
      check_load("toggle_load", NW);
      for (int k = 0; k < 3; k++) begin
         clr_counts();
         run_load(2, 2, 1'b0, -1, 1'b0);
         check_load("random_load", NW);
      end
   endtask

   task automatic test_reset_mid_load();
      start = 1'b1;
      tick();
      start   = 1'b0;
      s_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         s_data = DATA_W'($urandom_range(0, 16'hFFFF));
         tick();
      end
      rst_n   = 1'b0;
      s_valid = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0 || mem_we !== 1'b0 || load_done !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid_load busy=%b ready=%b we=%b done=%b required 0 0 0 0",
                  busy, s_ready, mem_we, load_done);
      end
      rst_n = 1'b1;
      tick();
      clr_counts();
      run_load(0, 2, 1'b0, -1, 1'b0);
      check_load("reload_after_reset", NW);
      n_checks++;
      if (first_addr !== 0) begin
         n_errors++;
         $display("FAIL reload_first_addr addr=%0d required 0", first_addr);
      end
   endtask

   task automatic test_restart_mid_load();
      clr_counts();
      run_load(0, 2, 1'b0, 3, 1'b0);
      check_load("restart_ignored", NW);
   endtask

   task automatic test_start_with_valid();
      clr_counts();
      run_load(2, 2, 1'b1, -1, 1'b0);
      check_load("start_with_valid", NW);
   endtask

   task automatic test_back_to_back();
      clr_counts();
      run_load(0, 2, 1'b0, -1, 1'b1);
      n_checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL start_in_done busy=%b ready=%b required 0 0", busy, s_ready);
      end
      check_load("first_of_pair", NW);
      clr_counts();
      run_load(2, 0, 1'b0, -1, 1'b0);
      check_load("second_of_pair", NW);
   endtask

`ifdef W1_LOAD_CHECKSUM_EN
   task automatic test_checksum();
      clr_counts();
      run_load(1, 1, 1'b0, -1, 1'b0);
      n_checks++;
      if (checksum !== (DATA_W+ADDR_W)'(36)) begin
         n_errors++;
         $display("FAIL checksum_1_to_8 checksum=%0d required 36", checksum);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_reset_mid_load();
      test_restart_mid_load();
      test_start_with_valid();
      test_back_to_back();
`ifdef W1_LOAD_CHECKSUM_EN
      test_checksum();
`endif
      tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL pending_writes left=%0d required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
